tx_scheduler: RTL and testbench
===============================

Name: tx_scheduler

Overview:
- Sequences the two transmit modes (Costas array and PSK) onto the shared DDS/MCU path.
- Latches transmission requests, arbitrates between them, and starts each transmission on a PPS edge.
- Generates the MCU trigger and symbol-clock strobes, plus the DDS frequency-update pulse (fq_ud) at every symbol boundary.
- Sits between the request inputs and the DDS/MCU outputs in the top level.

Parameters:
CLK_HZ, 27000000, sys_clk frequency
COSTAS_LEN, 7, symbols per Costas transmission
COSTAS_SYM_CYCLES, 2700000, sys_clk cycles per Costas symbol (10 sym/s)
PSK_SIGNAL_RATE_HZ, 125, PSK symbol rate; PSK symbol period = CLK_HZ/PSK_SIGNAL_RATE_HZ cycles
PSK_LEN, 64, symbols per PSK transmission
TRIG_CYCLES, 8, width of the mcu_*_trigger pulse
FQUD_CYCLES, 4, width of the fq_ud pulse

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pps  in  1  1 Hz pulse, asynchronous to sys_clk
costas_txrq  in  1  Costas transmission request (level)
psk_txrq  in  1  PSK transmission request (level)
mcu_costas_trigger  out  1  start-of-Costas pulse
mcu_costas_clk  out  1  Costas symbol clock
mcu_psk_trigger  out  1  start-of-PSK pulse
mcu_psk_clk  out  1  PSK symbol clock
fq_ud  out  1  DDS frequency-update pulse
sym_idx  out  8  current symbol index (0-based)
busy  out  1  transmission in progress
done  out  1  one-cycle pulse at end of transmission

Behaviour:
- Reset: all outputs 0; pending flags cleared; FSM in IDLE; pps synchroniser cleared.
- pps path:
  - 2-flop synchroniser followed by a rising-edge detector.
  - pps_tick is a 1-cycle pulse, 3 sys_clk edges after pps rises.
- Pending flags:
  - cos_pend is set on any cycle with costas_txrq=1; psk_pend likewise with psk_txrq=1.
  - A flag is cleared on the cycle its transmission starts.
  - If the request is still high on that same cycle, the set wins and the flag stays 1 (re-armed).
  - A request must be registered before the pps_tick cycle to be eligible at that tick.
- FSM states: IDLE, ACTIVE, FINISH.
- IDLE:
  - On pps_tick with cos_pend=1, start Costas.
  - Else on pps_tick with psk_pend=1, start PSK.
  - Costas has fixed priority; a losing PSK request stays pending for the next pps_tick.
  - pps_tick with nothing pending: no action.
- Start (cycle S = the cycle after pps_tick):
  - busy=1, sym_idx=0, symbol counter=0.
  - Selected mcu_*_trigger is high for cycles S..S+TRIG_CYCLES-1.
- ACTIVE:
  - The symbol counter counts 0..P-1, where P = COSTAS_SYM_CYCLES or CLK_HZ/PSK_SIGNAL_RATE_HZ.
  - At each count=0: fq_ud is high for FQUD_CYCLES cycles.
  - The selected mcu_*_clk is high while count < P/2 (integer division).
  - On count wrap, sym_idx increments.
  - The unselected mode's trigger and clk outputs stay 0.
- End of transmission:
  - When count=P-1 and sym_idx=LEN-1, go to FINISH.
  - FINISH lasts 1 cycle: done=1, busy=0, sym_idx=0, then IDLE.
  - A pps_tick in the FINISH cycle is not acted on.
- pps_tick during ACTIVE is ignored and does not resynchronise the symbol timing.
- New requests during ACTIVE set pending flags, including a request for the active mode, which is served at a later pps.
- rst asserted mid-transmission:
  - Next cycle, all outputs are 0 and pending flags are cleared.
  - The transmission is abandoned with no done pulse.
- Counter widths are sized from the parameters (clog2 of the maximum P).
- P, LEN, TRIG_CYCLES and FQUD_CYCLES are each >= 2.
- TRIG_CYCLES < P and FQUD_CYCLES < P/2.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=1000, COSTAS_SYM_CYCLES=20, PSK_SIGNAL_RATE_HZ=100 (P=10), COSTAS_LEN=7, PSK_LEN=4.
1. Single Costas:
   - Stimulus: costas_txrq pulse, then pps.
   - Trigger high 8 cycles starting 4 cycles after the pps rise.
   - 7 fq_ud pulses, 20 cycles apart, each 4 cycles wide; mcu_costas_clk high 10 / low 10.
   - sym_idx 0..6; done at cycle 140 after start; mcu_psk_* stay 0.
2. Simultaneous requests:
   - Stimulus: both requests, then pps.
   - Costas runs first; PSK (4 symbols, period 10, clk high 5) starts only at the next pps after done.
3. Request too late:
   - Stimulus: psk_txrq asserted on the pps_tick cycle.
   - No start on that tick; PSK starts on the following pps.
4. pps during ACTIVE:
   - Stimulus: extra pps pulses mid-transmission.
   - Symbol timing is unchanged; no restart; busy stays 1.
5. Mid-operation reset:
   - Stimulus: rst at Costas symbol 3.
   - All outputs 0 next cycle; no done pulse.
   - Subsequent pps with no request: nothing starts.
6. Re-arm while active:
   - Stimulus: costas_txrq held high continuously.
   - Back-to-back Costas transmissions, one per pps, with IDLE gaps between them.

Source files
------------

// File: rtl/tx_scheduler.sv
// tx_scheduler: latches Costas/PSK transmit requests, starts the winning
// mode on a synchronised PPS tick, and generates the MCU trigger, the MCU
// symbol clock and the DDS fq_ud strobe at every symbol boundary.
module tx_scheduler #(
  parameter int CLK_HZ             = 27000000,
  parameter int COSTAS_LEN         = 7,
  parameter int COSTAS_SYM_CYCLES  = 2700000,
  parameter int PSK_SIGNAL_RATE_HZ = 125,
  parameter int PSK_LEN            = 64,
  parameter int TRIG_CYCLES        = 8,
  parameter int FQUD_CYCLES        = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       pps,
  input  logic       costas_txrq,
  input  logic       psk_txrq,
  output logic       mcu_costas_trigger,
  output logic       mcu_costas_clk,
  output logic       mcu_psk_trigger,
  output logic       mcu_psk_clk,
  output logic       fq_ud,
  output logic [7:0] sym_idx,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int PSK_SYM_CYCLES = CLK_HZ / PSK_SIGNAL_RATE_HZ;
  localparam int P_MAX = (COSTAS_SYM_CYCLES > PSK_SYM_CYCLES) ? COSTAS_SYM_CYCLES
                                                              : PSK_SYM_CYCLES;
  localparam int CW = $clog2(P_MAX);

  localparam logic [CW-1:0] COS_LAST     = CW'(COSTAS_SYM_CYCLES - 1);
  localparam logic [CW-1:0] PSK_LAST     = CW'(PSK_SYM_CYCLES - 1);
  localparam logic [CW-1:0] COS_HALF     = CW'(COSTAS_SYM_CYCLES / 2);
  localparam logic [CW-1:0] PSK_HALF     = CW'(PSK_SYM_CYCLES / 2);
  localparam logic [CW-1:0] TRIG_END     = CW'(TRIG_CYCLES);
  localparam logic [CW-1:0] FQUD_END     = CW'(FQUD_CYCLES);
  localparam logic [7:0]    COS_SYM_LAST = 8'(COSTAS_LEN - 1);
  localparam logic [7:0]    PSK_SYM_LAST = 8'(PSK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_mode_psk;   // mode of the transmission in progress
  logic [CW-1:0]   r_cnt;        // cycle within the current symbol
  logic [7:0]      r_sym;

  logic            r_pps_s1;
  logic            r_pps_s2;
  logic            r_pps_s2_d;
  logic            r_pps_tick;

  logic            r_cos_pend;
  logic            r_psk_pend;

  logic            r_cos_trig;
  logic            r_cos_clk;
  logic            r_psk_trig;
  logic            r_psk_clk;
  logic            r_fq_ud;
  logic            r_busy;
  logic            r_done;

  logic            w_start_cos;
  logic            w_start_psk;
  logic [CW-1:0]   w_last_cnt;
  logic [CW-1:0]   w_half;
  logic [7:0]      w_last_sym;
  logic            w_wrap;
  logic            w_end;
  logic [CW-1:0]   w_cnt_nxt;
  logic [7:0]      w_sym_nxt;
  logic            w_trig_nxt;
  logic            w_clk_nxt;
  logic            w_fq_nxt;

  // Two-flop pps synchroniser and registered rising-edge detector;
  // the tick appears on the third sys_clk edge after pps rises.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pps_s1   <= 1'b0;
      r_pps_s2   <= 1'b0;
      r_pps_s2_d <= 1'b0;
      r_pps_tick <= 1'b0;
    end else begin
      r_pps_s1   <= pps;
      r_pps_s2   <= r_pps_s1;
      r_pps_s2_d <= r_pps_s2;
      r_pps_tick <= r_pps_s2 & ~r_pps_s2_d;
    end
  end

  // Arbitration: only an idle scheduler acts on a tick, Costas wins ties.
  always_comb begin
    w_start_cos = (r_state == S_IDLE) && r_pps_tick && r_cos_pend;
    w_start_psk = (r_state == S_IDLE) && r_pps_tick && !r_cos_pend && r_psk_pend;
  end

  // Pending flags: a request seen on the start cycle re-arms the flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_cos_pend <= 1'b0;
      r_psk_pend <= 1'b0;
    end else begin
      r_cos_pend <= (r_cos_pend & ~w_start_cos) | costas_txrq;
      r_psk_pend <= (r_psk_pend & ~w_start_psk) | psk_txrq;
    end
  end

  // Symbol timing for the active mode and the output levels of the next cycle.
  always_comb begin
    w_last_cnt = r_mode_psk ? PSK_LAST : COS_LAST;
    w_half     = r_mode_psk ? PSK_HALF : COS_HALF;
    w_last_sym = r_mode_psk ? PSK_SYM_LAST : COS_SYM_LAST;
    w_wrap     = (r_cnt == w_last_cnt);
    w_end      = w_wrap && (r_sym == w_last_sym);
    w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
    w_sym_nxt  = w_wrap ? r_sym + 8'd1 : r_sym;
    w_trig_nxt = (w_sym_nxt == 8'd0) && (w_cnt_nxt < TRIG_END);
    w_clk_nxt  = (w_cnt_nxt < w_half);
    w_fq_nxt   = (w_cnt_nxt < FQUD_END);
  end

  // Transmission FSM with registered strobes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode_psk <= 1'b0;
      r_cnt      <= '0;
      r_sym      <= 8'd0;
      r_cos_trig <= 1'b0;
      r_cos_clk  <= 1'b0;
      r_psk_trig <= 1'b0;
      r_psk_clk  <= 1'b0;
      r_fq_ud    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start_cos || w_start_psk) begin
            r_state    <= S_ACTIVE;
            r_mode_psk <= w_start_psk;
            r_cnt      <= '0;
            r_sym      <= 8'd0;
            r_busy     <= 1'b1;
            r_fq_ud    <= 1'b1;
            r_cos_trig <= w_start_cos;
            r_cos_clk  <= w_start_cos;
            r_psk_trig <= w_start_psk;
            r_psk_clk  <= w_start_psk;
          end
        end
        S_ACTIVE: begin
          if (w_end) begin
            r_state    <= S_FINISH;
            r_cnt      <= '0;
            r_sym      <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_fq_ud    <= 1'b0;
            r_cos_trig <= 1'b0;
            r_cos_clk  <= 1'b0;
            r_psk_trig <= 1'b0;
            r_psk_clk  <= 1'b0;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_sym      <= w_sym_nxt;
            r_fq_ud    <= w_fq_nxt;
            r_cos_trig <= !r_mode_psk && w_trig_nxt;
            r_cos_clk  <= !r_mode_psk && w_clk_nxt;
            r_psk_trig <= r_mode_psk && w_trig_nxt;
            r_psk_clk  <= r_mode_psk && w_clk_nxt;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mcu_costas_trigger = r_cos_trig;
  assign mcu_costas_clk     = r_cos_clk;
  assign mcu_psk_trigger    = r_psk_trig;
  assign mcu_psk_clk        = r_psk_clk;
  assign fq_ud              = r_fq_ud;
  assign sym_idx            = r_sym;
  assign busy               = r_busy;
  assign done               = r_done;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed scenarios with randomised timing, checked cycle
// by cycle against a transmission-level model of the scheduler.
module tb_tx_scheduler;

  localparam int CLK_HZ             = 1000;
  localparam int COSTAS_LEN         = 7;
  localparam int COSTAS_SYM_CYCLES  = 20;
  localparam int PSK_SIGNAL_RATE_HZ = 100;
  localparam int PSK_LEN            = 4;
  localparam int TRIG_CYCLES        = 8;
  localparam int FQUD_CYCLES        = 4;
  localparam int PSK_P              = CLK_HZ / PSK_SIGNAL_RATE_HZ;
  localparam int W                  = 15;
  localparam int MAXE               = 8192;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       pps;
  logic       costas_txrq;
  logic       psk_txrq;
  logic       mcu_costas_trigger;
  logic       mcu_costas_clk;
  logic       mcu_psk_trigger;
  logic       mcu_psk_clk;
  logic       fq_ud;
  logic [7:0] sym_idx;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  tx_scheduler #(
    .CLK_HZ             (CLK_HZ),
    .COSTAS_LEN         (COSTAS_LEN),
    .COSTAS_SYM_CYCLES  (COSTAS_SYM_CYCLES),
    .PSK_SIGNAL_RATE_HZ (PSK_SIGNAL_RATE_HZ),
    .PSK_LEN            (PSK_LEN),
    .TRIG_CYCLES        (TRIG_CYCLES),
    .FQUD_CYCLES        (FQUD_CYCLES)
  ) dut (
    .sys_clk            (sys_clk),
    .rst                (rst),
    .pps                (pps),
    .costas_txrq        (costas_txrq),
    .psk_txrq           (psk_txrq),
    .mcu_costas_trigger (mcu_costas_trigger),
    .mcu_costas_clk     (mcu_costas_clk),
    .mcu_psk_trigger    (mcu_psk_trigger),
    .mcu_psk_clk        (mcu_psk_clk),
    .fq_ud              (fq_ud),
    .sym_idx            (sym_idx),
    .busy               (busy),
    .done               (done),
    .dbg_state          (dbg_state)
  );

  // clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // reference model state
  int  e = 0;
  bit  pps_at [MAXE];
  bit  rst_at [MAXE];
  bit  m_cos;
  bit  m_psk;
  bit  m_has_tx;
  bit  m_mode_psk;
  int  m_start;
  logic [W-1:0] exp_q[$];

  // observed event counters per scenario
  int   n_done, n_fq_rise, n_ct_rise, n_pt_rise, n_cclk_hi, n_pclk_hi;
  logic p_fq, p_ct, p_pt;

  function automatic bit ps(int i);
    return (i >= 0) ? pps_at[i] : 1'b0;
  endfunction

  function automatic bit rs(int i);
    return (i >= 0) ? rst_at[i] : 1'b0;
  endfunction

  function automatic int tx_len(bit is_psk);
    return is_psk ? PSK_LEN : COSTAS_LEN;
  endfunction

  function automatic int tx_per(bit is_psk);
    return is_psk ? PSK_P : COSTAS_SYM_CYCLES;
  endfunction

  // Model of one rising clock edge; pushes the outputs expected after it.
  task automatic model_edge();
    bit tick, can_start, st_c, st_p;
    int k, len, per, c;
    logic [W-1:0] v;
    if (e >= MAXE) begin
      $display("FAIL model_edge_budget got=%0d exp<%0d", e, MAXE);
      $fatal(1, "edge budget");
    end
    pps_at[e] = pps;
    rst_at[e] = rst;
    if (rst) begin
      m_has_tx = 1'b0;
      m_cos    = 1'b0;
      m_psk    = 1'b0;
    end else begin
      // pps first sampled high three edges ago, not high the edge before,
      // and no reset wiping the synchroniser in between
      tick = ps(e-3) && !rs(e-3) && !rs(e-2) && !rs(e-1) && !(ps(e-4) && !rs(e-4));
      can_start = !m_has_tx ||
                  (e - m_start >= tx_len(m_mode_psk) * tx_per(m_mode_psk) + 2);
      st_c = tick && can_start && m_cos;
      st_p = tick && can_start && !m_cos && m_psk;
      if (st_c || st_p) begin
        m_has_tx   = 1'b1;
        m_start    = e;
        m_mode_psk = st_p;
      end
      m_cos = (m_cos && !st_c) || (costas_txrq === 1'b1);
      m_psk = (m_psk && !st_p) || (psk_txrq === 1'b1);
    end
    v = '0;
    if (m_has_tx) begin
      len = tx_len(m_mode_psk);
      per = tx_per(m_mode_psk);
      k   = e - m_start;
      if (k < len * per) begin
        c = k % per;
        v[10]  = (c < FQUD_CYCLES);
        v[9]   = 1'b1;
        v[7:0] = 8'(k / per);
        if (m_mode_psk) begin
          v[12] = (k < TRIG_CYCLES);
          v[11] = (c < per / 2);
        end else begin
          v[14] = (k < TRIG_CYCLES);
          v[13] = (c < per / 2);
        end
      end else if (k == len * per) begin
        v[8] = 1'b1;
      end
    end
    exp_q.push_back(v);
    e++;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0d exp=%0d", tag, e, got, exp);
    end
  endtask

  // scoreboard: compare DUT outputs with the oldest expected entry
  task automatic check_outputs();
    logic [W-1:0] v;
    v = exp_q.pop_front();
    chk("cos_trig", 16'(mcu_costas_trigger), 16'(v[14]));
    chk("cos_clk",  16'(mcu_costas_clk),     16'(v[13]));
    chk("psk_trig", 16'(mcu_psk_trigger),    16'(v[12]));
    chk("psk_clk",  16'(mcu_psk_clk),        16'(v[11]));
    chk("fq_ud",    16'(fq_ud),              16'(v[10]));
    chk("busy",     16'(busy),               16'(v[9]));
    chk("done",     16'(done),               16'(v[8]));
    chk("sym_idx",  16'(sym_idx),            16'(v[7:0]));
    if (done === 1'b1) n_done++;
    if (fq_ud === 1'b1 && p_fq !== 1'b1) n_fq_rise++;
    if (mcu_costas_trigger === 1'b1 && p_ct !== 1'b1) n_ct_rise++;
    if (mcu_psk_trigger === 1'b1 && p_pt !== 1'b1) n_pt_rise++;
    if (mcu_costas_clk === 1'b1) n_cclk_hi++;
    if (mcu_psk_clk === 1'b1) n_pclk_hi++;
    p_fq = fq_ud;
    p_ct = mcu_costas_trigger;
    p_pt = mcu_psk_trigger;
  endtask

  // driver tasks
  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pps_pulse(input int w);
    pps = 1'b1;
    repeat (w) step();
    pps = 1'b0;
  endtask

  task automatic clr_obs();
    n_done = 0; n_fq_rise = 0; n_ct_rise = 0; n_pt_rise = 0;
    n_cclk_hi = 0; n_pclk_hi = 0;
  endtask

  initial begin
    int w, x;
    rst = 1'b1; pps = 1'b0; costas_txrq = 1'b0; psk_txrq = 1'b0;
    p_fq = 1'b0; p_ct = 1'b0; p_pt = 1'b0;
    clr_obs();
    run(3);
    rst = 1'b0;
    run(5);

    // 1: single Costas transmission
    clr_obs();
    costas_txrq = 1'b1;
    run($urandom_range(3, 1));
    costas_txrq = 1'b0;
    run($urandom_range(6, 2));
    pps_pulse($urandom_range(5, 1));
    run(160);
    chk("s1_done_cnt", 16'(n_done), 16'd1);
    chk("s1_fq_pulses", 16'(n_fq_rise), 16'd7);
    chk("s1_cos_trig_cnt", 16'(n_ct_rise), 16'd1);
    chk("s1_psk_trig_cnt", 16'(n_pt_rise), 16'd0);
    chk("s1_cos_clk_hi", 16'(n_cclk_hi), 16'd70);
    chk("s1_psk_clk_hi", 16'(n_pclk_hi), 16'd0);

    // 2: simultaneous requests, Costas first then PSK on the next pps
    clr_obs();
    costas_txrq = 1'b1; psk_txrq = 1'b1;
    run($urandom_range(2, 1));
    costas_txrq = 1'b0; psk_txrq = 1'b0;
    run($urandom_range(6, 2));
    pps_pulse($urandom_range(4, 1));
    run(150 + $urandom_range(10, 0));
    pps_pulse($urandom_range(4, 1));
    run(60);
    chk("s2_done_cnt", 16'(n_done), 16'd2);
    chk("s2_cos_trig_cnt", 16'(n_ct_rise), 16'd1);
    chk("s2_psk_trig_cnt", 16'(n_pt_rise), 16'd1);
    chk("s2_fq_pulses", 16'(n_fq_rise), 16'd11);
    chk("s2_cos_clk_hi", 16'(n_cclk_hi), 16'd70);
    chk("s2_psk_clk_hi", 16'(n_pclk_hi), 16'd20);

    // 3: PSK request raised in the pps_tick cycle is too late for that tick
    clr_obs();
    w = $urandom_range(4, 1);
    pps = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == w - 1) pps = 1'b0;
      if (i == 2) psk_txrq = 1'b1;
      if (i == 3) psk_txrq = 1'b0;
    end
    run(10);
    chk("s3_no_start_busy", 16'(busy), 16'd0);
    chk("s3_no_start_trig", 16'(n_pt_rise), 16'd0);
    pps_pulse($urandom_range(3, 1));
    run(60);
    chk("s3_psk_trig_cnt", 16'(n_pt_rise), 16'd1);
    chk("s3_done_cnt", 16'(n_done), 16'd1);
    chk("s3_fq_pulses", 16'(n_fq_rise), 16'd4);

    // 4: extra pps pulses while a Costas transmission is active
    clr_obs();
    costas_txrq = 1'b1;
    step();
    costas_txrq = 1'b0;
    run(3);
    pps_pulse($urandom_range(3, 1));
    run(15 + $urandom_range(10, 0));
    pps_pulse(2);
    run(30 + $urandom_range(10, 0));
    pps_pulse(3);
    run(150);
    chk("s4_done_cnt", 16'(n_done), 16'd1);
    chk("s4_cos_trig_cnt", 16'(n_ct_rise), 16'd1);
    chk("s4_fq_pulses", 16'(n_fq_rise), 16'd7);

    // 5: reset in Costas symbol 3 with a PSK request pending
    clr_obs();
    costas_txrq = 1'b1;
    step();
    costas_txrq = 1'b0;
    run(3);
    w = $urandom_range(3, 1);
    x = $urandom_range(19, 0);
    pps_pulse(w);
    run(20);
    psk_txrq = 1'b1;
    step();
    psk_txrq = 1'b0;
    run(4 + 60 + x - w - 21);
    chk("s5_pre_rst_sym", 16'(sym_idx), 16'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_rst_busy", 16'(busy), 16'd0);
    chk("s5_rst_sym", 16'(sym_idx), 16'd0);
    run(5);
    pps_pulse(2);
    run(60);
    chk("s5_done_cnt", 16'(n_done), 16'd0);
    chk("s5_psk_trig_cnt", 16'(n_pt_rise), 16'd0);
    chk("s5_cos_trig_cnt", 16'(n_ct_rise), 16'd1);

    // 6: request held high re-arms; dropped request stays pending once more
    clr_obs();
    costas_txrq = 1'b1;
    run(3);
    for (int i = 0; i < 4; i++) begin
      pps_pulse($urandom_range(4, 1));
      if (i == 2) begin
        run(20);
        costas_txrq = 1'b0;
        run(140);
      end else begin
        run(150 + $urandom_range(10, 0));
      end
    end
    chk("s6_cos_trig_cnt", 16'(n_ct_rise), 16'd4);
    chk("s6_done_cnt", 16'(n_done), 16'd4);
    pps_pulse(2);
    run(30);
    chk("s6_after_cos_trig_cnt", 16'(n_ct_rise), 16'd4);
    chk("s6_psk_trig_cnt", 16'(n_pt_rise), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
